// File: rtl/accel_ip_axil_slave_if.sv
// AXI4-Lite bus bundle for the accel_ip register responder.
// Signal names match the block-design AXI port names.
interface accel_ip_axil_slave_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/accel_ip_axil_slave.sv
// accel_ip AXI4-Lite register bank responder, one write and one read in flight.
// Define ACCEL_IP_SLVERR_EN to answer unmapped word indices with SLVERR.
module accel_ip_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    accel_ip_axil_slave_if.slave                     s_axi,
    output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] regs_o,
    output logic [C_NUM_REGS-1:0]                    wr_pulse_o
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef ACCEL_IP_SLVERR_EN
    localparam logic [1:0] RESP_MISS = 2'b10;
`else
    localparam logic [1:0] RESP_MISS = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        r_wstate;
    r_state_t        r_rstate;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic            r_arready;
    logic            r_rvalid;
    logic [1:0]      r_rresp;
    logic [DW-1:0]   r_rdata;
    logic [IW-1:0]   r_awidx;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [DW-1:0]   r_regs [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] r_wr_pulse;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_ar_hs;
    logic            w_b_hs;
    logic            w_r_hs;
    logic            w_commit;
    logic [IW-1:0]   w_c_idx;
    logic [DW-1:0]   w_c_data;
    logic [SW-1:0]   w_c_strb;
    logic [C_NUM_REGS-1:0] w_c_sel;
    logic            w_c_hit;
    logic [IW-1:0]   w_ar_idx;
    logic [DW-1:0]   w_ar_data;
    logic            w_ar_hit;

    assign w_aw_hs  = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs   = s_axi.S_AXI_WVALID & r_wready;
    assign w_ar_hs  = s_axi.S_AXI_ARVALID & r_arready;
    assign w_b_hs   = r_bvalid & s_axi.S_AXI_BREADY;
    assign w_r_hs   = r_rvalid & s_axi.S_AXI_RREADY;
    assign w_ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Commit source: whichever half was latched earlier comes from the holding regs
    always_comb begin
        w_commit = 1'b0;
        w_c_idx  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_c_data = s_axi.S_AXI_WDATA;
        w_c_strb = s_axi.S_AXI_WSTRB;
        unique case (r_wstate)
            W_IDLE:    w_commit = w_aw_hs & w_w_hs;
            W_HAVE_AW: begin
                w_commit = w_w_hs;
                w_c_idx  = r_awidx;
            end
            W_HAVE_W:  begin
                w_commit = w_aw_hs;
                w_c_data = r_wdata;
                w_c_strb = r_wstrb;
            end
            default:   w_commit = 1'b0;
        endcase
    end

    always_comb begin
        w_c_sel   = '0;
        w_ar_data = '0;
        w_ar_hit  = 1'b0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            w_c_sel[k] = (w_c_idx == IW'(k));
            if (w_ar_idx == IW'(k)) begin
                w_ar_data = r_regs[k];
                w_ar_hit  = 1'b1;
            end
        end
    end

    assign w_c_hit = |w_c_sel;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < C_NUM_REGS; k++) r_regs[k] <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_c_sel : '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                for (int b = 0; b < SW; b++) begin
                    if (w_commit && w_c_sel[k] && w_c_strb[b])
                        r_regs[k][8*b +: 8] <= w_c_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_c_hit ? RESP_OKAY : RESP_MISS;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_HAVE_AW;
                        r_awidx   <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_HAVE_W;
                        r_wdata   <= s_axi.S_AXI_WDATA;
                        r_wstrb   <= s_axi.S_AXI_WSTRB;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_HAVE_AW, W_HAVE_W: r_wstate <= r_wstate;
                W_RESP: begin
                    if (w_b_hs) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_data;
                        r_rresp   <= w_ar_hit ? RESP_OKAY : RESP_MISS;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < C_NUM_REGS; k++) regs_o[k*DW +: DW] = r_regs[k];
    end

    assign wr_pulse_o          = r_wr_pulse;
    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;
endmodule

// File: tb/tb_accel_ip_axil_slave.sv
// Scoreboard bench for accel_ip_axil_slave.
// Honours ACCEL_IP_SLVERR_EN for the expected unmapped response.
module tb_accel_ip_axil_slave;
    localparam int NR = 4;
`ifdef ACCEL_IP_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [127:0] regs_o;
    logic [3:0]  wr_pulse_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mdl [NR];
    logic [1:0]  bq [$];
    exp_t        rq [$];

    accel_ip_axil_slave_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    accel_ip_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .C_NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .s_axi(bus.slave),
        .regs_o(regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic sync();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly, input int w_dly);
        int idx;
        int cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        logic [3:0] exp_pulse;
        idx = int'(a[5:2]);
        exp_pulse = '0;
        if (idx < NR) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(ERR);
        end
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) begin
                bus.S_AXI_AWADDR = a;
                bus.S_AXI_AWVALID = 1'b1;
            end
            if (!w_done && cyc >= w_dly) begin
                bus.S_AXI_WDATA = d;
                bus.S_AXI_WSTRB = s;
                bus.S_AXI_WVALID = 1'b1;
            end
            @(negedge ACLK);
            if (aw_done && !w_done) begin
                n_vec++;
                if (bus.S_AXI_AWREADY !== 1'b0) begin
                    n_err++;
                    $display("FAIL awready_in_have_aw: got %b want 0", bus.S_AXI_AWREADY);
                end
            end
            if (w_done && !aw_done) begin
                n_vec++;
                if (bus.S_AXI_WREADY !== 1'b0) begin
                    n_err++;
                    $display("FAIL wready_in_have_w: got %b want 0", bus.S_AXI_WREADY);
                end
            end
            hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            sync();
            if (hs_aw) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (hs_w)  begin bus.S_AXI_WVALID = 1'b0;  w_done = 1;  end
            cyc++;
        end
        n_vec++;
        if (!(aw_done && w_done)) begin
            n_err++;
            $display("FAIL write_timeout addr %h: aw %0d w %0d", a, aw_done, w_done);
        end
        n_vec++;
        if (wr_pulse_o !== exp_pulse) begin
            n_err++;
            $display("FAIL wr_pulse addr %h: got %b want %b", a, wr_pulse_o, exp_pulse);
        end
        sync();
        n_vec++;
        if (wr_pulse_o !== 4'b0) begin
            n_err++;
            $display("FAIL wr_pulse_clear addr %h: got %b want 0000", a, wr_pulse_o);
        end
    endtask

    task automatic get_bresp(input int hold);
        int cyc;
        logic [1:0] b0, eb;
        cyc = 0;
        @(negedge ACLK);
        while (bus.S_AXI_BVALID !== 1'b1 && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        n_vec++;
        if (bus.S_AXI_BVALID !== 1'b1) begin
            n_err++;
            $display("FAIL bvalid_timeout: got %b want 1", bus.S_AXI_BVALID);
        end
        b0 = bus.S_AXI_BRESP;
        for (int i = 0; i < hold; i++) begin
            n_vec++;
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== b0 ||
                bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) begin
                n_err++;
                $display("FAIL b_hold cyc %0d: bv %b bresp %b awr %b wr %b want 1 %b 0 0",
                         i, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                         bus.S_AXI_AWREADY, bus.S_AXI_WREADY, b0);
            end
            @(negedge ACLK);
        end
        eb = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        n_vec++;
        if (bus.S_AXI_BRESP !== eb) begin
            n_err++;
            $display("FAIL bresp: got %b want %b", bus.S_AXI_BRESP, eb);
        end
        bus.S_AXI_BREADY = 1'b1;
        sync();
        bus.S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1 ||
            bus.S_AXI_WREADY !== 1'b1) begin
            n_err++;
            $display("FAIL b_release: bv %b awr %b wr %b want 0 1 1",
                     bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
        sync();
    endtask

    task automatic axi_read(input logic [5:0] a, input int hold);
        int idx;
        int cyc;
        bit hs;
        exp_t e;
        logic [31:0] d0;
        idx = int'(a[5:2]);
        e.d = (idx < NR) ? mdl[idx] : 32'h0;
        e.r = (idx < NR) ? 2'b00 : ERR;
        rq.push_back(e);
        bus.S_AXI_ARADDR = a;
        bus.S_AXI_ARVALID = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 20) begin
            @(negedge ACLK);
            hs = (bus.S_AXI_ARREADY === 1'b1);
            sync();
            cyc++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        n_vec++;
        if (!hs) begin
            n_err++;
            $display("FAIL read_timeout addr %h: arready %b want 1", a, bus.S_AXI_ARREADY);
        end
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_RVALID !== 1'b1) begin
            n_err++;
            $display("FAIL rvalid_latency addr %h: got %b want 1", a, bus.S_AXI_RVALID);
        end
        d0 = bus.S_AXI_RDATA;
        for (int i = 0; i < hold; i++) begin
            n_vec++;
            if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== d0 ||
                bus.S_AXI_ARREADY !== 1'b0) begin
                n_err++;
                $display("FAIL r_hold cyc %0d: rv %b rdata %h arr %b want 1 %h 0",
                         i, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_ARREADY, d0);
            end
            @(negedge ACLK);
        end
        if (rq.size() > 0) e = rq.pop_front();
        n_vec++;
        if (bus.S_AXI_RDATA !== e.d || bus.S_AXI_RRESP !== e.r) begin
            n_err++;
            $display("FAIL rdata addr %h: got %h/%b want %h/%b",
                     a, bus.S_AXI_RDATA, bus.S_AXI_RRESP, e.d, e.r);
        end
        bus.S_AXI_RREADY = 1'b1;
        sync();
        bus.S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
            n_err++;
            $display("FAIL r_release: rv %b arr %b want 0 1",
                     bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        sync();
    endtask

    task automatic check_idle_zero(input string tag);
        n_vec++;
        if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0 ||
            bus.S_AXI_ARREADY !== 1'b0 || bus.S_AXI_BVALID !== 1'b0 ||
            bus.S_AXI_RVALID !== 1'b0 || wr_pulse_o !== 4'b0 ||
            bus.S_AXI_BRESP !== 2'b0 || bus.S_AXI_RRESP !== 2'b0 ||
            bus.S_AXI_RDATA !== 32'h0 || regs_o !== 128'h0) begin
            n_err++;
            $display("FAIL %s: awr %b wr %b arr %b bv %b rv %b pulse %b rdata %h regs %h want all 0",
                     tag, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                     bus.S_AXI_BVALID, bus.S_AXI_RVALID, wr_pulse_o,
                     bus.S_AXI_RDATA, regs_o);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check_idle_zero("reset_state");
        ARESETN = 1'b1;
        sync();
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1 ||
            bus.S_AXI_ARREADY !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: awr %b wr %b arr %b want 1 1 1",
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
        end
        sync();
    endtask

    task automatic test_basic_rw();
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
            get_bresp(0);
        end
        n_vec++;
        if (regs_o !== 128'h00000004_00000003_00000002_00000001) begin
            n_err++;
            $display("FAIL regs_o_basic: got %h want 00000004000000030000000200000001", regs_o);
        end
        for (int i = 0; i < 4; i++) axi_read(6'(4 * i), 0);
    endtask

    task automatic test_backpressure();
        axi_write(6'h00, 32'h1, 4'hF, 0, 0);
        get_bresp(5);
        axi_read(6'h08, 5);
    endtask

    task automatic test_strobe();
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        get_bresp(0);
        axi_write(6'h04, 32'h11223344, 4'b0101, 0, 0);
        get_bresp(0);
        n_vec++;
        if (regs_o[63:32] !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL strobe_merge: got %h want aa22cc44", regs_o[63:32]);
        end
        axi_read(6'h04, 0);
    endtask

    task automatic test_split_order();
        axi_write(6'h08, 32'hCAFE0008, 4'hF, 0, 3);
        get_bresp(0);
        axi_write(6'h0D, 32'hBEEF000C, 4'hF, 3, 0);
        get_bresp(0);
        axi_read(6'h0A, 0);
        axi_read(6'h0C, 0);
    endtask

    task automatic test_unmapped();
        logic [127:0] r0;
        r0 = regs_o;
        axi_write(6'h20, 32'hDEADBEEF, 4'hF, 0, 0);
        get_bresp(0);
        n_vec++;
        if (regs_o !== r0) begin
            n_err++;
            $display("FAIL unmapped_write: got %h want %h", regs_o, r0);
        end
        axi_read(6'h20, 0);
        axi_read(6'h3C, 0);
    endtask

    task automatic test_reset_mid();
        bus.S_AXI_AWADDR = 6'h04;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_AWREADY !== 1'b1) begin
            n_err++;
            $display("FAIL mid_awready: got %b want 1", bus.S_AXI_AWREADY);
        end
        sync();
        bus.S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        n_vec++;
        if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b1) begin
            n_err++;
            $display("FAIL mid_have_aw: awr %b wr %b want 0 1",
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        check_idle_zero("async_reset_mid");
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        bq.delete();
        rq.delete();
        @(negedge ACLK);
        ARESETN = 1'b1;
        sync();
        axi_write(6'h04, 32'h5A5AA5A5, 4'hF, 0, 0);
        get_bresp(0);
        n_vec++;
        if (regs_o !== {64'h0, 32'h5A5AA5A5, 32'h0}) begin
            n_err++;
            $display("FAIL post_reset_write: got %h want 0...5a5aa5a500000000", regs_o);
        end
        axi_read(6'h04, 0);
        axi_read(6'h00, 0);
    endtask

    initial begin
        bus.S_AXI_AWADDR = '0;
        bus.S_AXI_AWPROT = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARPROT = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        test_reset();
        test_basic_rw();
        test_backpressure();
        test_strobe();
        test_split_order();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
